rr_stream_unpacker: RTL and testbench

Replay-side counterpart of the record packing path. It consumes variable-length logging units from a stream bus (valid/data/len/ready) read back from storage. Each unit is split into its static part (logb_valid, loge_valid) and its dynamic part (the densely packed logb data). The packed logb data is re-expanded into fixed per-channel bit positions, so the replay decoder tree can route each channel's payload to its axichannel_replayer.

---
 rtl/rr_stream_unpacker.sv | 216 +++++++++++++++++++++
 tb/tb_rr_stream_unpacker.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_stream_unpacker.sv
// -----------------------------------------------------------------------------
// rr_stream_unpacker
//   Replay-side unpacker for variable-length logging units. Splits each unit
//   into its static part (logb_valid, loge_valid) and its densely packed logb
//   payload, then re-expands the payload so every channel sits at a fixed bit
//   offset for the replay decoder tree. Two-stage elastic pipeline
//   (A: offsets, B: unpacked result).
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   in_valid/ready  : input unit handshake
//   in_data         : {packed logb data, loge_valid, logb_valid} (LSB first)
//   in_len          : number of meaningful bits in in_data
//   out_valid/ready : output unit handshake
//   out_logb_valid  : per-channel logb valid
//   out_loge_valid  : loge valid bitmap
//   out_logb_data   : unpacked data, channel i at sum of widths of channels < i
//   len_err         : sticky, some unit had in_len != expected length
//   unit_cnt        : units accepted since reset (wraps)
// -----------------------------------------------------------------------------

package rr_stream_unpacker_pkg;

  // Channel widths are handled as a wide flat vector so the helpers can be
  // used in parameter declarations for any channel count / width encoding.
  localparam int unsigned RR_FLAT_BITS = 4096;

  // Width of channel idx out of a flat width table.
  function automatic int unsigned rr_width_at(input logic [RR_FLAT_BITS-1:0] flat,
                                              input int unsigned idx,
                                              input int unsigned wbits);
    logic [RR_FLAT_BITS-1:0] mask;
    mask = (RR_FLAT_BITS'(1) << wbits) - RR_FLAT_BITS'(1);
    return 32'((flat >> (idx * wbits)) & mask);
  endfunction

  // Sum of the first cnt channel widths.
  function automatic int unsigned rr_width_sum(input logic [RR_FLAT_BITS-1:0] flat,
                                               input int unsigned cnt,
                                               input int unsigned wbits);
    int unsigned sum;
    sum = 0;
    for (int unsigned i = 0; i < cnt; i++) begin
      sum = sum + rr_width_at(flat, i, wbits);
    end
    return sum;
  endfunction

endpackage

module rr_stream_unpacker
  import rr_stream_unpacker_pkg::*;
#(
  parameter int unsigned LOGB_CHANNEL_CNT      = 2,
  parameter int unsigned LOGE_CHANNEL_CNT      = 2,
  parameter int unsigned RR_CHANNEL_WIDTH_BITS = 8,
  parameter logic [LOGB_CHANNEL_CNT-1:0][RR_CHANNEL_WIDTH_BITS-1:0] CHANNEL_WIDTHS = {8'd4, 8'd8},
  localparam int unsigned LOGB_DATA_WIDTH =
    rr_width_sum(RR_FLAT_BITS'(CHANNEL_WIDTHS), LOGB_CHANNEL_CNT, RR_CHANNEL_WIDTH_BITS),
  localparam int unsigned FULL_WIDTH   = LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT + LOGB_DATA_WIDTH,
  localparam int unsigned OFFSET_WIDTH = $clog2(FULL_WIDTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [FULL_WIDTH-1:0]       in_data,
  input  logic [OFFSET_WIDTH-1:0]     in_len,
  output logic                        in_ready,
  output logic                        out_valid,
  output logic [LOGB_CHANNEL_CNT-1:0] out_logb_valid,
  output logic [LOGE_CHANNEL_CNT-1:0] out_loge_valid,
  output logic [LOGB_DATA_WIDTH-1:0]  out_logb_data,
  input  logic                        out_ready,
  output logic                        len_err,
  output logic [31:0]                 unit_cnt
);

  localparam int unsigned STATIC_W = LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT;
  localparam logic [RR_FLAT_BITS-1:0] CW_FLAT = RR_FLAT_BITS'(CHANNEL_WIDTHS);

  // Input field split
  logic [LOGB_CHANNEL_CNT-1:0]                   w_in_lv;
  logic [LOGE_CHANNEL_CNT-1:0]                   w_in_ev;
  logic [LOGB_DATA_WIDTH-1:0]                    w_in_pd;
  logic [LOGB_CHANNEL_CNT-1:0][OFFSET_WIDTH-1:0] w_in_poff;
  logic [OFFSET_WIDTH-1:0]                       w_in_tot;
  logic [OFFSET_WIDTH-1:0]                       w_in_exp_len;

  // Handshake
  logic w_b_load;
  logic w_a_load;
  logic w_in_fire;

  // Stage A
  logic                                          r_a_full;
  logic [LOGB_CHANNEL_CNT-1:0]                   r_a_lv;
  logic [LOGE_CHANNEL_CNT-1:0]                   r_a_ev;
  logic [LOGB_DATA_WIDTH-1:0]                    r_a_pd;
  logic [LOGB_CHANNEL_CNT-1:0][OFFSET_WIDTH-1:0] r_a_poff;
  logic [OFFSET_WIDTH-1:0]                       r_a_len;
  logic [OFFSET_WIDTH-1:0]                       r_a_exp_len;

  // Stage A -> B combinational unpack
  logic [LOGB_DATA_WIDTH-1:0] w_unp;

  // Stage B
  logic                        r_b_full;
  logic [LOGB_CHANNEL_CNT-1:0] r_b_lv;
  logic [LOGE_CHANNEL_CNT-1:0] r_b_ev;
  logic [LOGB_DATA_WIDTH-1:0]  r_b_data;

  logic        r_len_err;
  logic [31:0] r_unit_cnt;

  assign w_in_lv = in_data[LOGB_CHANNEL_CNT-1:0];
  assign w_in_ev = in_data[LOGB_CHANNEL_CNT +: LOGE_CHANNEL_CNT];
  assign w_in_pd = in_data[FULL_WIDTH-1:STATIC_W];

  // Unrolled prefix sum: a channel's packed start is the end of the previous
  // channel, which only advances when that channel is present.
  for (genvar g = 0; g < LOGB_CHANNEL_CNT; g++) begin : g_poff
    localparam int unsigned CH_W = rr_width_at(CW_FLAT, g, RR_CHANNEL_WIDTH_BITS);
    logic [OFFSET_WIDTH-1:0] w_start;
    logic [OFFSET_WIDTH-1:0] w_end;
    if (g == 0) begin : g_first
      assign w_start = '0;
    end else begin : g_rest
      assign w_start = g_poff[g-1].w_end;
    end
    assign w_end        = w_start + (w_in_lv[g] ? OFFSET_WIDTH'(CH_W) : '0);
    assign w_in_poff[g] = w_start;
  end

  assign w_in_tot     = g_poff[LOGB_CHANNEL_CNT-1].w_end;
  assign w_in_exp_len = OFFSET_WIDTH'(STATIC_W) + w_in_tot;

  // Re-expand: absent channels are zero, pd bits beyond the packed total are
  // never selected.
  for (genvar g = 0; g < LOGB_CHANNEL_CNT; g++) begin : g_unp
    localparam int unsigned CH_W = rr_width_at(CW_FLAT, g, RR_CHANNEL_WIDTH_BITS);
    localparam int unsigned UOFF = rr_width_sum(CW_FLAT, g, RR_CHANNEL_WIDTH_BITS);
    assign w_unp[UOFF +: CH_W] = r_a_lv[g] ? CH_W'(r_a_pd >> r_a_poff[g]) : '0;
  end

  // Elastic advance: B moves when it can hand off, A moves when B takes it.
  assign w_b_load  = !r_b_full || out_ready;
  assign w_a_load  = !r_a_full || w_b_load;
  assign w_in_fire = in_valid && w_a_load;
  assign in_ready  = w_a_load;

  // Stage A register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_full    <= 1'b0;
      r_a_lv      <= '0;
      r_a_ev      <= '0;
      r_a_pd      <= '0;
      r_a_poff    <= '0;
      r_a_len     <= '0;
      r_a_exp_len <= '0;
    end else if (w_a_load) begin
      r_a_full <= in_valid;
      if (in_valid) begin
        r_a_lv      <= w_in_lv;
        r_a_ev      <= w_in_ev;
        r_a_pd      <= w_in_pd;
        r_a_poff    <= w_in_poff;
        r_a_len     <= in_len;
        r_a_exp_len <= w_in_exp_len;
      end
    end
  end

  // Stage B register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_b_full <= 1'b0;
      r_b_lv   <= '0;
      r_b_ev   <= '0;
      r_b_data <= '0;
    end else if (w_b_load) begin
      r_b_full <= r_a_full;
      if (r_a_full) begin
        r_b_lv   <= r_a_lv;
        r_b_ev   <= r_a_ev;
        r_b_data <= w_unp;
      end
    end
  end

  // Sticky length check, evaluated while the unit sits in stage A
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len_err <= 1'b0;
    end else if (r_a_full && (r_a_len != r_a_exp_len)) begin
      r_len_err <= 1'b1;
    end
  end

  // Accepted-unit counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_unit_cnt <= '0;
    end else if (w_in_fire) begin
      r_unit_cnt <= r_unit_cnt + 32'd1;
    end
  end

  assign out_valid      = r_b_full;
  assign out_logb_valid = r_b_lv;
  assign out_loge_valid = r_b_ev;
  assign out_logb_data  = r_b_data;
  assign len_err        = r_len_err;
  assign unit_cnt       = r_unit_cnt;

endmodule

// File: tb/tb_rr_stream_unpacker.sv
// -----------------------------------------------------------------------------
// tb_rr_stream_unpacker
//   Self-checking bench for rr_stream_unpacker with default parameters
//   (ch0 = 8 bits, ch1 = 4 bits, 2 loge channels). Directed steps followed by
//   a randomized phase, all outputs compared against a bit-walking model.
// -----------------------------------------------------------------------------
module tb_rr_stream_unpacker;

  localparam int FW = 16;
  localparam int LW = 12;
  localparam int OW = 5;
  localparam int CW[2] = '{8, 4};

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [FW-1:0] in_data;
  logic [OW-1:0] in_len;
  logic          in_ready;
  logic          out_valid;
  logic [1:0]    out_logb_valid;
  logic [1:0]    out_loge_valid;
  logic [LW-1:0] out_logb_data;
  logic          out_ready;
  logic          len_err;
  logic [31:0]   unit_cnt;

  rr_stream_unpacker dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_len         (in_len),
    .in_ready       (in_ready),
    .out_valid      (out_valid),
    .out_logb_valid (out_logb_valid),
    .out_loge_valid (out_loge_valid),
    .out_logb_data  (out_logb_data),
    .out_ready      (out_ready),
    .len_err        (len_err),
    .unit_cnt       (unit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    lv;
    logic [1:0]    ev;
    logic [LW-1:0] data;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_cnt  = 0;
  bit   m_err  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Walks the packed payload with a cursor; present channels consume bits.
  function automatic exp_t model(input logic [FW-1:0] d);
    exp_t e;
    int   cur;
    int   uo;
    e.lv   = d[1:0];
    e.ev   = d[3:2];
    e.data = '0;
    cur    = 4;
    uo     = 0;
    for (int ch = 0; ch < 2; ch++) begin
      if (d[ch]) begin
        for (int b = 0; b < CW[ch]; b++) begin
          if (cur + b < FW) e.data[uo + b] = d[cur + b];
        end
        cur += CW[ch];
      end
      uo += CW[ch];
    end
    return e;
  endfunction

  function automatic int exp_len(input logic [FW-1:0] d);
    return 4 + (d[0] ? CW[0] : 0) + (d[1] ? CW[1] : 0);
  endfunction

  // One clock: sample handshakes before the edge, update model, check counter.
  task automatic step(output bit acc);
    bit   out_fire;
    exp_t e;
    #2;
    acc      = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    check("in_ready", 32'(in_ready), 32'(!(q.size() == 2 && !out_ready)));
    if (q.size() == 0) check("out_valid_idle", 32'(out_valid), 32'd0);
    if (out_valid && q.size() > 0) begin
      e = q[0];
      check("out_logb_valid", 32'(out_logb_valid), 32'(e.lv));
      check("out_loge_valid", 32'(out_loge_valid), 32'(e.ev));
      check("out_logb_data",  32'(out_logb_data),  32'(e.data));
    end
    if (out_fire && q.size() > 0) void'(q.pop_front());
    if (acc) begin
      q.push_back(model(in_data));
      m_cnt++;
      if (int'(in_len) != exp_len(in_data)) m_err = 1'b1;
    end
    @(posedge clk);
    #1;
    check("unit_cnt", unit_cnt, 32'(m_cnt));
  endtask

  task automatic send(input logic [FW-1:0] d, input logic [OW-1:0] l);
    bit acc;
    int guard;
    acc      = 1'b0;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_len   = l;
    while (!acc && guard < 50) begin
      step(acc);
      guard++;
    end
    checks++;
    assert (acc) else begin
      errors++;
      $error("FAIL send_timeout observed=%0d expected=%0d", acc, 1);
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(acc);
  endtask

  // Send one unit with a free output and check it one edge after acceptance.
  task automatic directed(input string tag, input logic [FW-1:0] d, input logic [OW-1:0] l,
                          input logic [1:0] lv, input logic [1:0] ev, input logic [LW-1:0] data);
    out_ready = 1'b1;
    send(d, l);
    check({tag, "_lat0_valid"}, 32'(out_valid), 32'd0);
    idle(1);
    check({tag, "_valid"}, 32'(out_valid),      32'd1);
    check({tag, "_lv"},    32'(out_logb_valid), 32'(lv));
    check({tag, "_ev"},    32'(out_loge_valid), 32'(ev));
    check({tag, "_data"},  32'(out_logb_data),  32'(data));
  endtask

  function automatic logic [FW-1:0] rand_unit();
    return 16'($urandom);
  endfunction

  initial begin
    logic [FW-1:0] u[3];
    logic [FW-1:0] d;
    bit            acc;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_len    = '0;
    out_ready = 1'b1;
    #12;
    check("rst_in_ready",  32'(in_ready),       32'd1);
    check("rst_out_valid", 32'(out_valid),      32'd0);
    check("rst_lv",        32'(out_logb_valid), 32'd0);
    check("rst_ev",        32'(out_loge_valid), 32'd0);
    check("rst_data",      32'(out_logb_data),  32'd0);
    check("rst_len_err",   32'(len_err),        32'd0);
    check("rst_unit_cnt",  unit_cnt,            32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single channel, both channels, empty logb
    directed("single", 16'h00A6, 5'd8, 2'b10, 2'b01, 12'hA00);
    check("single_len_err", 32'(len_err), 32'd0);
    check("single_cnt", unit_cnt, 32'd1);
    directed("both", 16'h35C3, 5'd16, 2'b11, 2'b00, 12'h35C);
    directed("empty", 16'h000C, 5'd4, 2'b00, 2'b11, 12'h000);
    check("ok_len_err", 32'(len_err), 32'd0);

    // Length mismatch: forwarded unchanged, sticky error
    directed("badlen", 16'h35C3, 5'd12, 2'b11, 2'b00, 12'h35C);
    check("badlen_len_err", 32'(len_err), 32'd1);
    for (int i = 0; i < 10; i++) begin
      d = rand_unit();
      send(d, 5'(exp_len(d)));
    end
    idle(3);
    check("sticky_len_err", 32'(len_err), 32'(m_err));

    // Backpressure: only two units fit, then drain on consecutive cycles
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) u[k] = rand_unit();
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = u[k];
      in_len  = 5'(exp_len(u[k]));
      step(acc);
    end
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_cnt", unit_cnt, 32'(m_cnt));
    check("bp_cnt_two", 32'(m_cnt - 20), 32'(unit_cnt - 32'd20));
    idle(3);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("bp_drain_valid", 32'(out_valid), 32'd1);
      check("bp_drain_data", 32'(out_logb_data), 32'(model(u[k]).data));
      step(acc);
      in_valid = 1'b0;
    end
    check("bp_drain_empty", 32'(out_valid), 32'd0);

    // Reset with both stages full
    out_ready = 1'b0;
    send(16'h35C3, 5'd16);
    send(16'h00A6, 5'd8);
    idle(1);
    #1;
    rst = 1'b1;
    #1;
    check("mrst_out_valid", 32'(out_valid),     32'd0);
    check("mrst_in_ready",  32'(in_ready),      32'd1);
    check("mrst_cnt",       unit_cnt,           32'd0);
    check("mrst_len_err",   32'(len_err),       32'd0);
    check("mrst_data",      32'(out_logb_data), 32'd0);
    q.delete();
    m_cnt = 0;
    m_err = 1'b0;
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    directed("post_rst", 16'h00A6, 5'd8, 2'b10, 2'b01, 12'hA00);
    check("post_rst_cnt", unit_cnt, 32'd1);

    // Randomized traffic with random backpressure and occasional bad lengths
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      d         = rand_unit();
      in_data   = d;
      in_len    = ($urandom_range(7) == 0) ? 5'($urandom_range(16)) : 5'(exp_len(d));
      out_ready = ($urandom_range(3) != 0);
      step(acc);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(5);
    check("final_drain", 32'(q.size()), 32'd0);
    check("final_out_valid", 32'(out_valid), 32'd0);
    check("final_len_err", 32'(len_err), 32'(m_err));
    check("final_cnt", unit_cnt, 32'(m_cnt));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
